// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode timing sequencer for the basic accumulator computer.
// Drives the T0-T3 fetch and indirect cycles, then hands off to execute.
module fetch_decode_ctrl #(
  parameter int CNT_W   = 16,
  parameter int OPC_LSB = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [15:0]      ir_in,
  input  logic             exec_done,
  input  logic             halt,
  output logic             mem_read,
  output logic             pc_incr,
  output logic             ld_ar,
  output logic             ld_ir,
  output logic             ld_i,
  output logic             bus_sel_pc,
  output logic             bus_sel_ir,
  output logic             bus_sel_mem,
  output logic [3:0]       t_state,
  output logic [7:0]       opcode_d,
  output logic             i_flag,
  output logic             exec_start,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_EXEC,
    S_HALT
  } state_t;

  state_t state;
  state_t state_n;
  logic   first_q;
  logic   indirect;

  logic unused_ir;
  assign unused_ir = &{1'b0, ir_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      opcode_d    <= '0;
      i_flag      <= 1'b0;
      first_q     <= 1'b0;
      instr_count <= '0;
    end else begin
      state   <= state_n;
      first_q <= (state == S_T3);
      if (state == S_T2) begin
        opcode_d <= 8'b1 << ir_in[OPC_LSB +: 3];
        i_flag   <= ir_in[15];
      end
      if (state == S_EXEC && exec_done) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (run) state_n = S_T0;
      S_T0:   state_n = S_T1;
      S_T1:   state_n = S_T2;
      S_T2:   state_n = S_T3;
      S_T3:   state_n = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          if (halt)     state_n = S_HALT;
          else if (run) state_n = S_T0;
          else          state_n = S_IDLE;
        end
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

  // Indirect fetch only for memory-reference opcodes (D7 is reg/IO)
  assign indirect = i_flag & ~opcode_d[7];

  always_comb begin
    mem_read    = 1'b0;
    pc_incr     = 1'b0;
    ld_ar       = 1'b0;
    ld_ir       = 1'b0;
    ld_i        = 1'b0;
    bus_sel_pc  = 1'b0;
    bus_sel_ir  = 1'b0;
    bus_sel_mem = 1'b0;
    t_state     = 4'b0000;
    exec_start  = 1'b0;
    halted      = 1'b0;
    unique case (state)
      S_T0: begin
        t_state    = 4'b0001;
        bus_sel_pc = 1'b1;
        ld_ar      = 1'b1;
      end
      S_T1: begin
        t_state     = 4'b0010;
        mem_read    = 1'b1;
        bus_sel_mem = 1'b1;
        ld_ir       = 1'b1;
        pc_incr     = 1'b1;
      end
      S_T2: begin
        t_state    = 4'b0100;
        bus_sel_ir = 1'b1;
        ld_ar      = 1'b1;
        ld_i       = 1'b1;
      end
      S_T3: begin
        t_state     = 4'b1000;
        mem_read    = indirect;
        bus_sel_mem = indirect;
        ld_ar       = indirect;
      end
      S_EXEC: exec_start = first_q;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    assert ($onehot0({bus_sel_pc, bus_sel_ir, bus_sel_mem}));
  end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench for fetch_decode_ctrl: directed and random
// instructions checked cycle by cycle against an instruction-level model.
module tb_fetch_decode_ctrl;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [15:0]   ir_in;
  logic          exec_done;
  logic          halt;
  logic          mem_read, pc_incr, ld_ar, ld_ir, ld_i;
  logic          bus_sel_pc, bus_sel_ir, bus_sel_mem;
  logic [3:0]    t_state;
  logic [7:0]    opcode_d;
  logic          i_flag;
  logic          exec_start;
  logic          halted;
  logic [CW-1:0] instr_count;

  int vectors = 0;
  int errors  = 0;

  logic [CW-1:0] exp_cnt = '0;
  logic [7:0]    exp_opc = '0;
  logic          exp_i   = 1'b0;

  wire [7:0] strobes = {mem_read, pc_incr, ld_ar, ld_ir, ld_i,
                        bus_sel_pc, bus_sel_ir, bus_sel_mem};

  always #5 clk = ~clk;

  fetch_decode_ctrl #(.CNT_W(CW), .OPC_LSB(12)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir_in(ir_in),
    .exec_done(exec_done), .halt(halt),
    .mem_read(mem_read), .pc_incr(pc_incr), .ld_ar(ld_ar),
    .ld_ir(ld_ir), .ld_i(ld_i), .bus_sel_pc(bus_sel_pc),
    .bus_sel_ir(bus_sel_ir), .bus_sel_mem(bus_sel_mem),
    .t_state(t_state), .opcode_d(opcode_d), .i_flag(i_flag),
    .exec_start(exec_start), .halted(halted),
    .instr_count(instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] s,
                      input logic [3:0] t, input bit st, input bit hl);
    @(negedge clk);
    chk({tag, "_strb"}, {24'd0, strobes}, {24'd0, s});
    chk({tag, "_t"}, {28'd0, t_state}, {28'd0, t});
    chk({tag, "_start"}, {31'd0, exec_start}, {31'd0, st});
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, hl});
    chk({tag, "_opc"}, {24'd0, opcode_d}, {24'd0, exp_opc});
    chk({tag, "_i"}, {31'd0, i_flag}, {31'd0, exp_i});
    chk({tag, "_cnt"}, {{(32-CW){1'b0}}, instr_count},
        {{(32-CW){1'b0}}, exp_cnt});
    @(posedge clk);
    #1;
  endtask

  // Entered with the sequencer in T0; leaves it at the instruction boundary
  task automatic run_instr(input logic [15:0] ir, input int lat,
                           input bit h, input bit run_end,
                           input bit run_mid);
    bit ind;
    ir_in     = ir;
    exec_done = 1'b0;
    halt      = 1'b0;
    run       = run_mid;
    step("t0", 8'h24, 4'b0001, 1'b0, 1'b0);
    step("t1", 8'hD1, 4'b0010, 1'b0, 1'b0);
    step("t2", 8'h2A, 4'b0100, 1'b0, 1'b0);
    exp_opc = 8'd1 << ir[14:12];
    exp_i   = ir[15];
    ind     = ir[15] && (ir[14:12] != 3'd7);
    ir_in   = 16'($urandom);
    step("t3", ind ? 8'hA1 : 8'h00, 4'b1000, 1'b0, 1'b0);
    for (int k = 0; k <= lat; k++) begin
      ir_in     = 16'($urandom);
      exec_done = (k == lat);
      halt      = (k == lat) ? h : 1'($urandom);
      run       = (k == lat) ? run_end : 1'($urandom);
      step("ex", 8'h00, 4'b0000, k == 0, 1'b0);
      if (k == lat) exp_cnt = exp_cnt + 1'b1;
    end
    exec_done = 1'b0;
    halt      = 1'b0;
  endtask

  initial begin
    int n;
    bit re;
    rst_n     = 1'b0;
    run       = 1'b0;
    ir_in     = '0;
    exec_done = 1'b0;
    halt      = 1'b0;
    #2;
    chk("rst_strb", {24'd0, strobes}, 32'd0);
    chk("rst_cnt", {{(32-CW){1'b0}}, instr_count}, 32'd0);
    chk("rst_opc", {24'd0, opcode_d}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("idle", 8'h00, 4'b0000, 1'b0, 1'b0);
    run = 1'b1;
    step("idle", 8'h00, 4'b0000, 1'b0, 1'b0);

    run_instr(16'h2005, 0, 1'b0, 1'b1, 1'b1);
    chk("d2005_opc", {24'd0, opcode_d}, 32'h04);
    run_instr(16'hA005, 1, 1'b0, 1'b1, 1'b1);
    run_instr(16'hF001, 0, 1'b0, 1'b1, 1'b1);
    chk("dF001_opc7", {31'd0, opcode_d[7]}, 32'd1);

    for (int i = 0; i < 40; i++) begin
      re = ($urandom_range(0, 3) != 0);
      run_instr(16'($urandom), $urandom_range(0, 3), 1'b0, re,
                1'($urandom));
      if (!re) begin
        run = 1'b0;
        step("idle", 8'h00, 4'b0000, 1'b0, 1'b0);
        step("idle", 8'h00, 4'b0000, 1'b0, 1'b0);
        run = 1'b1;
        step("idle", 8'h00, 4'b0000, 1'b0, 1'b0);
      end
    end

    n = (1 << CW) - int'(exp_cnt);
    for (int i = 0; i < n; i++)
      run_instr(16'($urandom), 0, 1'b0, 1'b1, 1'b1);
    chk("wrap_cnt", {{(32-CW){1'b0}}, instr_count}, 32'd0);

    run_instr(16'h1234, 2, 1'b0, 1'b0, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 3; i++)
      step("idle", 8'h00, 4'b0000, 1'b0, 1'b0);
    run = 1'b1;
    step("idle", 8'h00, 4'b0000, 1'b0, 1'b0);

    step("t0", 8'h24, 4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    chk("prerst_t1", {24'd0, strobes}, 32'hD1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    exp_opc = '0;
    exp_i   = 1'b0;
    chk("midrst_strb", {24'd0, strobes}, 32'd0);
    chk("midrst_t", {28'd0, t_state}, 32'd0);
    chk("midrst_cnt", {{(32-CW){1'b0}}, instr_count}, 32'd0);
    chk("midrst_opc", {24'd0, opcode_d}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b0;
    step("idle", 8'h00, 4'b0000, 1'b0, 1'b0);
    run = 1'b1;
    step("idle", 8'h00, 4'b0000, 1'b0, 1'b0);

    run_instr(16'h7001, 5, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom);
      exec_done = 1'($urandom);
      step("hlt", 8'h00, 4'b0000, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
